// File: rtl/multichannel_fifo.sv
// Multi-channel FIFO: CHANNELS independent first-word-fall-through queues sharing
// one write port and one read port, with per-channel flush and occupancy.
module multichannel_fifo #(
  parameter int WIDTH             = 8,
  parameter int DEPTH             = 4,
  parameter int CHANNELS          = 2,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  localparam int CHANNEL_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LEVEL_WIDTH      = $clog2(DEPTH + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            write_enable,
  input  logic [CHANNEL_WIDTH-1:0]        write_channel,
  input  logic [WIDTH-1:0]                write_data,
  output logic [CHANNELS-1:0]             write_full,
  output logic [CHANNELS-1:0]             write_almost_full,
  input  logic                            read_enable,
  input  logic [CHANNEL_WIDTH-1:0]        read_channel,
  output logic [WIDTH-1:0]                read_data,
  output logic [CHANNELS-1:0]             read_empty,
  input  logic [CHANNELS-1:0]             flush,
  output logic [CHANNELS*LEVEL_WIDTH-1:0] level,
  output logic                            write_error,
  output logic                            read_error
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] FULL_COUNT = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] AF_COUNT   = LEVEL_WIDTH'(ALMOST_FULL_LEVEL);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  logic [WIDTH-1:0]       mem    [CHANNELS][DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr [CHANNELS];
  logic [PTR_WIDTH-1:0]   rd_ptr [CHANNELS];
  logic [LEVEL_WIDTH-1:0] count  [CHANNELS];
  logic [CHANNELS-1:0]    push;
  logic [CHANNELS-1:0]    pop;

  // Status comes only from the registered counters.
  always_comb begin
    write_full        = '0;
    write_almost_full = '0;
    read_empty        = '0;
    level             = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      write_full[c]                        = (count[c] == FULL_COUNT);
      write_almost_full[c]                 = (count[c] >= AF_COUNT);
      read_empty[c]                        = (count[c] == '0);
      level[c*LEVEL_WIDTH +: LEVEL_WIDTH]  = count[c];
    end
  end

  // Out-of-range channel numbers match no channel and are therefore rejected.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push[c] = write_enable && (write_channel == CHANNEL_WIDTH'(c)) &&
                !write_full[c] && !flush[c];
      pop[c]  = read_enable && (read_channel == CHANNEL_WIDTH'(c)) &&
                !read_empty[c] && !flush[c];
    end
  end

  always_comb begin
    read_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (read_channel == CHANNEL_WIDTH'(c)) read_data = mem[c][rd_ptr[c]];
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!reset && push[c]) mem[c][wr_ptr[c]] <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      write_error <= 1'b0;
      read_error  <= 1'b0;
    end else begin
      write_error <= write_enable && !(|push);
      read_error  <= read_enable && !(|pop);
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          count[c]  <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= next_ptr(wr_ptr[c]);
          if (pop[c])  rd_ptr[c] <= next_ptr(rd_ptr[c]);
          if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
          else if (pop[c] && !push[c]) count[c] <= count[c] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multichannel_fifo.sv
// Bench for multichannel_fifo: directed vector tables on a DEPTH=4/CHANNELS=2 instance,
// random traffic against per-channel queue models on a DEPTH=5/CHANNELS=3 instance.
module tb_multichannel_fifo;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // Instance A: DEPTH=4, CHANNELS=2, ALMOST_FULL_LEVEL=3
  logic       a_we, a_wc, a_re, a_rc, a_werr, a_rerr;
  logic [7:0] a_wd, a_rd;
  logic [1:0] a_full, a_af, a_empty, a_fl;
  logic [5:0] a_level;

  multichannel_fifo #(.WIDTH(8), .DEPTH(4), .CHANNELS(2)) u_a (
    .clock(clock), .reset(reset),
    .write_enable(a_we), .write_channel(a_wc), .write_data(a_wd),
    .write_full(a_full), .write_almost_full(a_af),
    .read_enable(a_re), .read_channel(a_rc), .read_data(a_rd),
    .read_empty(a_empty), .flush(a_fl), .level(a_level),
    .write_error(a_werr), .read_error(a_rerr)
  );

  // Instance B: DEPTH=5, CHANNELS=3, ALMOST_FULL_LEVEL=4
  logic       b_we, b_re, b_werr, b_rerr;
  logic [1:0] b_wc, b_rc;
  logic [7:0] b_wd, b_rd;
  logic [2:0] b_full, b_af, b_empty, b_fl;
  logic [8:0] b_level;

  multichannel_fifo #(.WIDTH(8), .DEPTH(5), .CHANNELS(3)) u_b (
    .clock(clock), .reset(reset),
    .write_enable(b_we), .write_channel(b_wc), .write_data(b_wd),
    .write_full(b_full), .write_almost_full(b_af),
    .read_enable(b_re), .read_channel(b_rc), .read_data(b_rd),
    .read_empty(b_empty), .flush(b_fl), .level(b_level),
    .write_error(b_werr), .read_error(b_rerr)
  );

  typedef struct {
    logic       we, wc;
    logic [7:0] wd;
    logic       re, rc;
    logic [1:0] fl;
    logic       chk;
    logic [7:0] rd;
    logic [2:0] l0, l1;
    logic [1:0] full, af, empty;
    logic       werr, rerr;
  } vec_t;

  vec_t t1[$], t2[$], t3[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] q1[$];
  logic [7:0] mq[3][$];

  function automatic vec_t mk(input int we, wc, wd, re, rc, fl, chk, rd,
                              input int l0, l1, full, af, empty, werr, rerr);
    vec_t v;
    v.we = 1'(we);     v.wc = 1'(wc);     v.wd = 8'(wd);
    v.re = 1'(re);     v.rc = 1'(rc);     v.fl = 2'(fl);
    v.chk = 1'(chk);   v.rd = 8'(rd);
    v.l0 = 3'(l0);     v.l1 = 3'(l1);
    v.full = 2'(full); v.af = 2'(af);     v.empty = 2'(empty);
    v.werr = 1'(werr); v.rerr = 1'(rerr);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic a_drive(input logic we, wc, input logic [7:0] wd,
                         input logic re, rc, input logic [1:0] fl);
    @(negedge clock);
    a_we = we; a_wc = wc; a_wd = wd; a_re = re; a_rc = rc; a_fl = fl;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    a_drive(v.we, v.wc, v.wd, v.re, v.rc, v.fl);
    #1;
    if (v.chk) check({tag, " rdata"}, a_rd, v.rd);
    @(posedge clock);
    #1;
    check({tag, " level"}, a_level, {v.l1, v.l0});
    check({tag, " flags"}, {a_full, a_af, a_empty, a_werr, a_rerr},
          {v.full, v.af, v.empty, v.werr, v.rerr});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " A level"}, a_level, 6'd0);
    check({tag, " A flags"}, {a_full, a_af, a_empty, a_werr, a_rerr}, 8'b00_00_11_0_0);
    check({tag, " B level"}, b_level, 9'd0);
    check({tag, " B flags"}, {b_full, b_af, b_empty, b_werr, b_rerr}, 11'b000_000_111_0_0);
  endtask

  task automatic random_b();
    int wbias, rbias, wc_i, rc_i;
    logic wacc, racc;
    logic [8:0] el;
    logic [2:0] ef, eaf, ee;
    for (int i = 0; i < 1000; i++) begin
      case ((i / 100) % 3)
        0:       begin wbias = 3; rbias = 1; end
        1:       begin wbias = 1; rbias = 3; end
        default: begin wbias = 2; rbias = 2; end
      endcase
      @(negedge clock);
      b_we = ($urandom_range(0, 3) < wbias);
      b_re = ($urandom_range(0, 3) < rbias);
      b_wc = 2'($urandom_range(0, 3));
      b_rc = 2'($urandom_range(0, 3));
      b_wd = 8'($urandom);
      for (int c = 0; c < 3; c++) b_fl[c] = ($urandom_range(0, 15) == 0);
      wc_i = b_wc;
      rc_i = b_rc;
      wacc = b_we && wc_i < 3 && !b_fl[wc_i[1:0]] && mq[wc_i[1:0]].size() < 5;
      racc = b_re && rc_i < 3 && !b_fl[rc_i[1:0]] && mq[rc_i[1:0]].size() > 0;
      #1;
      if (rc_i < 3 && mq[rc_i[1:0]].size() > 0)
        check($sformatf("rand%0d rdata ch%0d", i, rc_i), b_rd, mq[rc_i[1:0]][0]);
      @(posedge clock);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (b_fl[c]) mq[c].delete();
        else begin
          if (racc && rc_i == c) void'(mq[c].pop_front());
          if (wacc && wc_i == c) mq[c].push_back(b_wd);
        end
      end
      for (int c = 0; c < 3; c++) begin
        el[c*3 +: 3] = 3'(mq[c].size());
        ef[c]  = (mq[c].size() == 5);
        eaf[c] = (mq[c].size() >= 4);
        ee[c]  = (mq[c].size() == 0);
      end
      check($sformatf("rand%0d level", i), b_level, el);
      check($sformatf("rand%0d flags", i), {b_full, b_af, b_empty, b_werr, b_rerr},
            {ef, eaf, ee, b_we && !wacc, b_re && !racc});
    end
    @(negedge clock);
    b_we = 0; b_re = 0; b_fl = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Fill/drain ch0, rejected push/pop, same-cycle push+pop at empty and full, ch1 fill.
    t1.push_back(mk(1,0,'h11,0,0,0,0,0,    1,0,0,0,2,0,0));
    t1.push_back(mk(1,0,'h22,0,0,0,0,0,    2,0,0,0,2,0,0));
    t1.push_back(mk(1,0,'h33,0,0,0,0,0,    3,0,0,1,2,0,0));
    t1.push_back(mk(1,0,'h44,0,0,0,0,0,    4,0,1,1,2,0,0));
    t1.push_back(mk(1,0,'h55,0,0,0,0,0,    4,0,1,1,2,1,0));
    t1.push_back(mk(0,0,0,0,0,0,0,0,       4,0,1,1,2,0,0));
    t1.push_back(mk(0,0,0,1,0,0,1,'h11,    3,0,0,1,2,0,0));
    t1.push_back(mk(0,0,0,1,0,0,1,'h22,    2,0,0,0,2,0,0));
    t1.push_back(mk(0,0,0,1,0,0,1,'h33,    1,0,0,0,2,0,0));
    t1.push_back(mk(0,0,0,1,0,0,1,'h44,    0,0,0,0,3,0,0));
    t1.push_back(mk(0,0,0,1,0,0,0,0,       0,0,0,0,3,0,1));
    t1.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,0,3,0,0));
    t1.push_back(mk(1,0,'ha1,1,0,0,0,0,    1,0,0,0,2,0,1));
    t1.push_back(mk(1,0,'ha2,0,0,0,0,0,    2,0,0,0,2,0,0));
    t1.push_back(mk(1,0,'ha3,0,0,0,0,0,    3,0,0,1,2,0,0));
    t1.push_back(mk(1,0,'ha4,0,0,0,0,0,    4,0,1,1,2,0,0));
    t1.push_back(mk(1,0,'ha5,1,0,0,1,'ha1, 3,0,0,1,2,1,0));
    t1.push_back(mk(1,1,'hc1,0,0,0,0,0,    3,1,0,1,0,0,0));
    t1.push_back(mk(1,1,'hc2,0,0,0,0,0,    3,2,0,1,0,0,0));
    // Flush ch0 against a push, then check ch1 untouched and ch0 restarts cleanly.
    t2.push_back(mk(1,0,'hff,0,0,1,0,0,    0,2,0,0,1,1,0));
    t2.push_back(mk(1,0,'he1,1,1,0,1,'hd8, 1,1,0,0,0,0,0));
    t2.push_back(mk(0,0,0,1,0,0,1,'he1,    0,1,0,0,1,0,0));
    t2.push_back(mk(1,0,'he2,0,0,0,0,0,    1,1,0,0,0,0,0));
    t2.push_back(mk(1,0,'he3,0,0,0,0,0,    2,1,0,0,0,0,0));
    // After the mid-operation reset the first new word must come back first.
    t3.push_back(mk(1,0,'hf1,0,0,0,0,0,    1,0,0,0,2,0,0));
    t3.push_back(mk(0,0,0,1,0,0,1,'hf1,    0,0,0,0,3,0,0));

    reset = 1'b1;
    a_we = 0; a_wc = 0; a_wd = 0; a_re = 0; a_rc = 0; a_fl = '0;
    b_we = 0; b_wc = 0; b_wd = 0; b_re = 0; b_rc = 0; b_fl = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset");
    @(negedge clock);
    reset = 1'b0;

    foreach (t1[i]) run_vec(t1[i], $sformatf("t1[%0d]", i));

    // Ten push+pop cycles on ch1 at level 2: pointers wrap, order must hold.
    q1.push_back(8'hc1);
    q1.push_back(8'hc2);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'hd0 + 8'(i);
      a_drive(1, 1, d, 1, 1, 2'b00);
      q1.push_back(d);
      #1;
      check($sformatf("wrap%0d rdata", i), a_rd, q1.pop_front());
      @(posedge clock);
      #1;
      check($sformatf("wrap%0d level", i), a_level, {3'd2, 3'd3});
      check($sformatf("wrap%0d flags", i), {a_full, a_af, a_empty, a_werr, a_rerr},
            8'b00_01_00_0_0);
    end

    foreach (t2[i]) run_vec(t2[i], $sformatf("t2[%0d]", i));

    // Reset with entries queued and a concurrent push: reset wins.
    a_drive(1, 0, 8'he4, 0, 0, 2'b00);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_state("midreset");
    @(negedge clock);
    reset = 1'b0;
    a_we = 0;

    foreach (t3[i]) run_vec(t3[i], $sformatf("t3[%0d]", i));

    a_drive(0, 0, 8'h00, 0, 0, 2'b00);
    random_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
